// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, strobes the instruction memory, latches the IR
// and computes the next PC (sequential, branch, jump, jump-register) on request.
//
// state | meaning
// FETCH | im_r high, waiting for fetch_en to capture im_rd into ir
// HOLD  | ir valid and stable, waiting for pc_wr to load next_pc
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_wr,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jr_addr,
  input  logic [31:0] im_rd,
  output logic [31:0] im_addr,
  output logic        im_r,
  output logic        im_w,
  output logic [31:0] im_wd,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] link,
  output logic        misalign,
  output logic        seq_err,
  output logic [31:0] instr_count
);

  typedef enum logic {FETCH, HOLD} state_t;
  state_t state;

  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign im_addr = pc;
  assign im_w    = 1'b0;
  assign im_wd   = 32'h0000_0000;
  assign br_off  = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Targets are relative to link (pc+4 of the instruction in ir), modulo 2^32.
  always_comb begin
    next_pc = link;
    case (pc_sel)
      2'b00:   next_pc = link;
      2'b01:   next_pc = link + br_off;
      2'b10:   next_pc = {link[31:28], ir[25:0], 2'b00};
      default: next_pc = {jr_addr[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= 32'h0000_0000;
      link        <= 32'h0000_0000;
      ir_valid    <= 1'b0;
      im_r        <= 1'b1;
      misalign    <= 1'b0;
      seq_err     <= 1'b0;
      instr_count <= 32'h0000_0000;
    end else begin
      case (state)
        FETCH: begin
          if (pc_wr)
            seq_err <= 1'b1;
          if (fetch_en) begin
            ir          <= im_rd;
            link        <= pc + 32'd4;
            instr_count <= instr_count + 32'd1;
            ir_valid    <= 1'b1;
            im_r        <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (pc_wr) begin
            pc <= next_pc;
            if (pc_sel == 2'b11 && jr_addr[1:0] != 2'b00)
              misalign <= 1'b1;
            ir_valid <= 1'b0;
            im_r     <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: each fetch pushes the expected ir/pc/link/count,
// a monitor pops and compares whenever ir_valid rises.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_wr;
  logic [1:0]  pc_sel;
  logic [31:0] jr_addr;
  logic [31:0] im_rd;
  logic [31:0] im_addr;
  logic        im_r;
  logic        im_w;
  logic [31:0] im_wd;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] link;
  logic        misalign;
  logic        seq_err;
  logic [31:0] instr_count;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .jr_addr(jr_addr), .im_rd(im_rd), .im_addr(im_addr), .im_r(im_r), .im_w(im_w),
    .im_wd(im_wd), .pc(pc), .ir(ir), .ir_valid(ir_valid), .link(link),
    .misalign(misalign), .seq_err(seq_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // IM aliases every 128 bytes: only address bits [6:2] decode.
  logic [31:0] mem [32];
  assign im_rd = mem[im_addr[6:2]];

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] link;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_pc;
  logic [31:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare against the scoreboard on every rising ir_valid.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (ir_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: got ir %h with empty scoreboard", ir);
        end else begin
          e = sbq.pop_front();
          chk("ir", ir, e.ir);
          chk("ir_pc", pc, e.pc);
          chk("link", link, e.link);
          chk("instr_count", instr_count, e.cnt);
          chk("ir_known", {31'b0, $isunknown(ir)}, 32'd0);
          chk("im_r_hold", {31'b0, im_r}, 32'd0);
        end
      end
      prev_valid = ir_valid;
    end
  end

  task automatic fetch();
    exp_t e;
    logic got;
    e.ir   = mem[cur_pc[6:2]];
    e.pc   = cur_pc;
    e.link = cur_pc + 32'd4;
    exp_count = exp_count + 32'd1;
    e.cnt  = exp_count;
    sbq.push_back(e);
    fetch_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = (ir_valid === 1'b1);
    end
    chk("fetch_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic advance(input logic [1:0] sel, input logic [31:0] jr,
                         input logic [31:0] exp_pc, input string name);
    pc_wr   = 1'b1;
    pc_sel  = sel;
    jr_addr = jr;
    @(negedge clk);
    pc_wr = 1'b0;
    chk(name, pc, exp_pc);
    chk("ir_valid_fetch", {31'b0, ir_valid}, 32'd0);
    cur_pc = exp_pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 + i;
    mem[0]  = 32'h0000_000A;
    mem[6]  = 32'h1422_0002;  // bne imm 2, at 0x18
    mem[10] = 32'h0800_000D;  // j 0x34, at 0x28
    mem[13] = 32'h0800_0016;  // j 0x58, at 0x34
    mem[22] = 32'h0C00_001A;  // jal 0x68, at 0x58
    mem[23] = 32'h03E0_0008;
    mem[26] = 32'h03E0_0008;

    rst = 1'b1; fetch_en = 1'b0; pc_wr = 1'b0; pc_sel = 2'b00; jr_addr = 32'h0;
    cur_pc = 32'h0; exp_count = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_im_r", {31'b0, im_r}, 32'd1);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_flags", {30'b0, misalign, seq_err}, 32'd0);
    chk("im_w", {31'b0, im_w}, 32'd0);
    rst = 1'b0;

    fetch();
    advance(2'b00, 32'h0, 32'h04, "seq_4");
    fetch();
    advance(2'b00, 32'h0, 32'h08, "seq_8");  fetch();
    advance(2'b00, 32'h0, 32'h0C, "seq_c");  fetch();
    advance(2'b00, 32'h0, 32'h10, "seq_10"); fetch();
    advance(2'b00, 32'h0, 32'h14, "seq_14"); fetch();
    advance(2'b00, 32'h0, 32'h18, "seq_18"); fetch();
    advance(2'b00, 32'h0, 32'h1C, "bne_not_taken"); fetch();
    advance(2'b11, 32'h18, 32'h18, "jr_18"); fetch();
    advance(2'b01, 32'h0, 32'h24, "bne_taken"); fetch();
    advance(2'b00, 32'h0, 32'h28, "seq_28"); fetch();
    advance(2'b10, 32'h0, 32'h34, "j_34"); fetch();
    advance(2'b10, 32'h0, 32'h58, "j_58"); fetch();
    chk("jal_link", link, 32'h5C);
    advance(2'b10, 32'h0, 32'h68, "jal_68"); fetch();
    advance(2'b11, 32'h5C, 32'h5C, "jr_5c");
    chk("misalign_clear", {31'b0, misalign}, 32'd0);
    fetch();
    advance(2'b11, 32'h5A, 32'h58, "jr_5a_aligned");
    chk("misalign_set", {31'b0, misalign}, 32'd1);
    fetch();
    chk("misalign_sticky", {31'b0, misalign}, 32'd1);

    fetch_en = 1'b0;
    advance(2'b00, 32'h0, 32'h5C, "seq_5c");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, ir_valid}, 32'd0);
      chk("stall_ir", ir, 32'h0C00_001A);
      chk("stall_pc", pc, 32'h5C);
      chk("stall_count", instr_count, 32'd16);
    end
    chk("seq_err_clear", {31'b0, seq_err}, 32'd0);
    pc_wr = 1'b1; pc_sel = 2'b01;
    @(negedge clk);
    pc_wr = 1'b0;
    chk("stall_pcwr_pc", pc, 32'h5C);
    chk("seq_err_set", {31'b0, seq_err}, 32'd1);
    fetch();
    advance(2'b11, 32'h34, 32'h34, "jr_34"); fetch();
    chk("hold_pc_34", pc, 32'h34);
    chk("seq_err_sticky", {31'b0, seq_err}, 32'd1);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_link", link, 32'h0);
    chk("arst_valid", {31'b0, ir_valid}, 32'd0);
    chk("arst_count", instr_count, 32'h0);
    chk("arst_flags", {30'b0, misalign, seq_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_pc = 32'h0;
    exp_count = 32'h0;
    fetch();
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
